// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns NUM_BTNS debounced button levels into
// PRESS / RELEASE / HOLD (and optionally REPEAT) events. Each button owns a
// small UP/DOWN/HELD FSM and three pending flags. A round-robin arbiter
// moves at most one pending event per cycle into a small FIFO, whose head
// is presented on a ready/valid stream.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while HELD,
// events of type 11). When undefined, HELD is static.
module button_event_arbiter #(
  parameter int NUM_BTNS      = 4,
  parameter int IDX_W         = 2,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int CNT_W         = 27,
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int FIFO_DEPTH    = 4,
  parameter int FIFO_AW       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_db,
  input  logic                event_ready,
  output logic                event_valid,
  output logic [IDX_W-1:0]    event_btn,
  output logic [1:0]          event_type,
  output logic                event_drop
);

  typedef enum logic [1:0] {ST_UP = 2'b00, ST_DOWN = 2'b01, ST_HELD = 2'b10} state_e;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_HOLD    = 2'b10;
  localparam int         EV_W       = IDX_W + 2;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FIFO_AW:0]  FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  // Elaboration guard: the shared counter must reach both terminal counts.
  if (CNT_W < $clog2(HOLD_CYCLES) || CNT_W < $clog2(REPEAT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLD_CYCLES / REPEAT_CYCLES");
  end

  state_e              st_q   [NUM_BTNS];
  state_e              st_d   [NUM_BTNS];
  logic [CNT_W-1:0]    cnt_q  [NUM_BTNS];
  logic [CNT_W-1:0]    cnt_d  [NUM_BTNS];
  logic [NUM_BTNS-1:0] set_p, set_r, set_h;
  logic [NUM_BTNS-1:0] pend_p_q, pend_p_d, pend_r_q, pend_r_d, pend_h_q, pend_h_d;
  logic [NUM_BTNS-1:0] pend_any, clr_p, clr_r, clr_h;
  logic                drop_q, drop_d;
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [1:0]       EV_REPEAT   = 2'b11;
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [NUM_BTNS-1:0] set_rep, rep_q, rep_d;
`endif

  logic                pop, push, grant_ok, gnt_any;
  logic [IDX_W-1:0]    gnt_idx, cand, rr_q, rr_d;
  logic [1:0]          gnt_type;
  logic [EV_W-1:0]     mem_q [FIFO_DEPTH];
  logic [EV_W-1:0]     mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_ptr;
  logic [FIFO_AW:0]    count_q, count_d;

  // Per-button FSM: next state, counter and the event each button raises.
  always_comb begin
    set_p = '0;
    set_r = '0;
    set_h = '0;
`ifdef BTN_AUTOREPEAT_EN
    set_rep = '0;
`endif
    for (int i = 0; i < NUM_BTNS; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        ST_UP: begin
          if (btn_db[i]) begin
            st_d[i]  = ST_DOWN;
            cnt_d[i] = '0;
            set_p[i] = 1'b1;
          end
        end
        ST_DOWN: begin
          if (!btn_db[i]) begin
            st_d[i]  = ST_UP;
            set_r[i] = 1'b1;
          end else if (cnt_q[i] == HOLD_LAST) begin
            st_d[i]  = ST_HELD;
            cnt_d[i] = '0;
            set_h[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_HELD: begin
          if (!btn_db[i]) begin
            st_d[i]  = ST_UP;
            set_r[i] = 1'b1;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (cnt_q[i] == REPEAT_LAST) begin
              cnt_d[i]   = '0;
              set_h[i]   = 1'b1;
              set_rep[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
`endif
          end
        end
        default: begin
          st_d[i]  = ST_UP;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Round-robin pick starting after the last granted button; PRESS wins
  // over HOLD/REPEAT, which wins over RELEASE, so press precedes release.
  always_comb begin
    pop      = event_valid & event_ready;
    grant_ok = (count_q < FIFO_FULL) | pop;
    pend_any = pend_p_q | pend_r_q | pend_h_q;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_BTNS; k++) begin
      if (int'(rr_q) + k >= NUM_BTNS) cand = IDX_W'(int'(rr_q) + k - NUM_BTNS);
      else                            cand = IDX_W'(int'(rr_q) + k);
      if (!gnt_any && pend_any[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    push  = grant_ok & gnt_any;
    clr_p = '0;
    clr_r = '0;
    clr_h = '0;
    if (pend_p_q[gnt_idx]) begin
      gnt_type       = EV_PRESS;
      clr_p[gnt_idx] = push;
    end else if (pend_h_q[gnt_idx]) begin
`ifdef BTN_AUTOREPEAT_EN
      gnt_type       = rep_q[gnt_idx] ? EV_REPEAT : EV_HOLD;
`else
      gnt_type       = EV_HOLD;
`endif
      clr_h[gnt_idx] = push;
    end else begin
      gnt_type       = EV_RELEASE;
      clr_r[gnt_idx] = push;
    end
    rr_d = push ? gnt_idx : rr_q;
  end

  // Pending flags: a set wins over a same-cycle grant; setting a flag that
  // is still waiting loses one event and raises event_drop next cycle.
  always_comb begin
    pend_p_d = (pend_p_q & ~clr_p) | set_p;
    pend_r_d = (pend_r_q & ~clr_r) | set_r;
    pend_h_d = (pend_h_q & ~clr_h) | set_h;
    drop_d   = |((set_p & pend_p_q & ~clr_p) |
                 (set_r & pend_r_q & ~clr_r) |
                 (set_h & pend_h_q & ~clr_h));
`ifdef BTN_AUTOREPEAT_EN
    rep_d = (rep_q & ~set_h) | set_rep;
`endif
  end

  // Event FIFO: write granted event at the tail, advance head on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {gnt_idx, gnt_type};
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    // When empty keep showing the most recently popped entry.
    head_ptr = (count_q == '0) ? rd_ptr_q - FIFO_AW'(1) : rd_ptr_q;
  end

  assign event_valid = (count_q != '0);
  assign event_btn   = mem_q[head_ptr][EV_W-1:2];
  assign event_type  = mem_q[head_ptr][1:0];
  assign event_drop  = drop_q;

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        st_q[i]  <= ST_UP;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      pend_h_q <= '0;
      drop_q   <= 1'b0;
      rr_q     <= IDX_W'(NUM_BTNS - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      pend_h_q <= pend_h_d;
      drop_q   <= drop_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Sits between the per-button debouncers and the game logic. It converts NUM_BTNS debounced button levels into discrete PRESS / RELEASE / HOLD events. Pending events are shared onto one ready/valid event stream through a round-robin arbiter and a small FIFO, so game FSMs consume one event at a time and never miss a tap.

Parameters:
NUM_BTNS, 4, number of debounced button inputs
IDX_W, 2, width of button index (clog2 NUM_BTNS, min 1)
HOLD_CYCLES, 100_000_000, cycles in DOWN before a HOLD event (1 s at 100 MHz)
CNT_W, 27, width of per-button hold/repeat counter; must hold HOLD_CYCLES-1 and REPEAT_CYCLES-1
REPEAT_CYCLES, 25_000_000, auto-repeat period (only used with optional feature)
FIFO_DEPTH, 4, event FIFO entries, power of two
FIFO_AW, 2, log2 FIFO_DEPTH

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_db  input  NUM_BTNS  debounced button levels, 1 = pressed
event_ready  input  1  consumer accepts head event
event_valid  output  1  FIFO non-empty
event_btn  output  IDX_W  button index of head event
event_type  output  2  00 PRESS, 01 RELEASE, 10 HOLD, 11 REPEAT
event_drop  output  1  one-cycle pulse: a detected event was lost

Behaviour:
- Reset (async, high): all button FSMs UP, counters 0, pending flags 0, FIFO empty, rr pointer = NUM_BTNS-1. Outputs: event_valid 0, event_btn 0, event_type 00, event_drop 0.
- A button held through reset release produces PRESS after reset.
- Per-button FSM, states UP / DOWN / HELD:
  - UP: btn_db=1 -> DOWN, counter<=0, set pending PRESS.
  - DOWN: btn_db=0 -> UP, set RELEASE. Else if counter==HOLD_CYCLES-1 -> HELD, counter<=0, set HOLD. Else counter+1.
  - HELD: btn_db=0 -> UP, set RELEASE. Otherwise stay (see optional feature).
  - Illegal state encoding -> UP.
- HOLD pending is set exactly HOLD_CYCLES cycles after the PRESS pending flag is set.
- Pending flags: three per button (PRESS, RELEASE, HOLD/REPEAT).
  - Set by the FSM, cleared on grant.
  - If a flag is set while already set: flag stays 1, event_drop pulses next cycle.
  - Set and grant of the same flag in the same cycle: flag stays 1 (new event queued).
- Arbiter, one grant per cycle:
  - Grant allowed when FIFO count < FIFO_DEPTH, or a pop occurs this cycle (simultaneous push/pop at full is legal).
  - Button order: round-robin starting at rr+1, wrapping. rr <= granted index.
  - Within one button: PRESS > HOLD/REPEAT > RELEASE, so press always precedes release.
- FIFO:
  - Head is driven directly on event_btn/event_type. Pop when event_valid & event_ready.
  - Outputs hold stable while valid & !ready.
  - event_btn/event_type are don't-care when empty; drive the last head value.
- Latency: btn_db seen high in cycle c -> pending set at end of c -> granted in c+1 -> event_valid=1 in c+2 (FIFO empty, no contention).
- FIFO full: pending flags wait; no loss until a flag is re-set (drop rule).

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: in HELD, counter increments each cycle. At counter==REPEAT_CYCLES-1, counter<=0 and the HOLD/REPEAT flag is set with type REPEAT (11).
  - The first HOLD is still type 10; all later events from that flag are type 11.
- Undefined: HELD is static, type 11 is never produced, REPEAT_CYCLES is unused.

Test Plan (bench uses HOLD_CYCLES=8, REPEAT_CYCLES=4, FIFO_DEPTH=4):
- Reset, btn_db[0] 0->1 at cycle c, ready=1 -> event_valid in c+2, btn 0, PRESS. Release 3 cycles later -> RELEASE event, no HOLD.
- btn_db[1] held 20 cycles -> PRESS, then HOLD (type 10) pending 8 cycles after PRESS pending, then RELEASE after drop. Macro on: type 11 events every 4 cycles in between.
- btn_db=4'b1111 in one cycle, ready=1 -> PRESS events in order btn 0,1,2,3. Next simultaneous release -> RELEASE order 0,1,2,3 (rr continues from 3).
- ready=0, 5 tap events -> 4 in FIFO, 5th stays pending, event_drop=0. Ready high -> all 5 delivered in order, head stable while stalled.
- ready=0, FIFO full, button 2 tapped twice -> second PRESS set hits a set flag -> event_drop pulses 1 cycle; one PRESS for btn 2 delivered.
- Assert reset while btn_db[0]=1 and FIFO holds 2 events -> event_valid 0 immediately. After release, PRESS for btn 0 is the first event.
